// File: rtl/fir4_stream_if.sv
// Sample/result stream and datapath tap bus between fir4_stream_ctrl and its surroundings.
// slave is the controller's view; master is the environment (source, sink, FIR datapath).
interface fir4_stream_if #(
    parameter int CNT_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic             flush;
    logic [31:0]      flt_data_in;
    logic [11:0]      flt_data_out;
    logic             m_valid;
    logic             m_ready;
    logic [11:0]      m_data;
    logic [CNT_W-1:0] out_cnt;
    logic [1:0]       state;

    modport slave (
        input  s_valid, s_data, flush, flt_data_out, m_ready,
        output s_ready, flt_data_in, m_valid, m_data, out_cnt, state
    );

    modport master (
        output s_valid, s_data, flush, flt_data_out, m_ready,
        input  s_ready, flt_data_in, m_valid, m_data, out_cnt, state
    );
endinterface

// File: rtl/fir4_stream_ctrl.sv
// Streaming controller for a 4-tap FIR datapath: sample window, warm-up, flush,
// registered result with valid/ready output and a wrapping result counter.
module fir4_stream_ctrl #(
    parameter bit ZERO_FILL = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fir4_stream_if.slave  bus
);
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       w0_q, w1_q, w2_q, w0_d, w1_d, w2_d;
    logic [1:0]       fill_q, fill_d;
    logic             mv_q, mv_d;
    logic [11:0]      md_q, md_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             produce;

    // The datapath sees the window as it would be after accepting s_data.
    assign bus.flt_data_in = {w2_q, w1_q, w0_q, bus.s_data};
    assign bus.s_ready     = (state_q != FLUSH) & ~bus.flush & (~mv_q | bus.m_ready);
    assign accept          = bus.s_valid & bus.s_ready;
    // fill_q==3 before the accept covers both the 4th sample and steady state.
    assign produce         = accept & (ZERO_FILL || (fill_q == 2'd3));

    assign bus.m_valid = mv_q;
    assign bus.m_data  = md_q;
    assign bus.out_cnt = cnt_q;
    assign bus.state   = state_q;

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                FILL:    if (produce) state_d = RUN;
                RUN:     state_d = RUN;
                FLUSH:   state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_comb begin
        w0_d   = w0_q;
        w1_d   = w1_q;
        w2_d   = w2_q;
        fill_d = fill_q;
        mv_d   = mv_q;
        md_d   = md_q;
        cnt_d  = cnt_q;
        if (state_q == FLUSH) begin
            w0_d   = 8'd0;
            w1_d   = 8'd0;
            w2_d   = 8'd0;
            fill_d = 2'd0;
        end else if (accept) begin
            w2_d = w1_q;
            w1_d = w0_q;
            w0_d = bus.s_data;
            if (fill_q != 2'd3) fill_d = fill_q + 2'd1;
        end
        if (produce) begin
            mv_d  = 1'b1;
            md_d  = bus.flt_data_out;
            cnt_d = cnt_q + CNT_W'(1);
        end else if (bus.m_ready) begin
            mv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            w0_q    <= 8'd0;
            w1_q    <= 8'd0;
            w2_q    <= 8'd0;
            fill_q  <= 2'd0;
            mv_q    <= 1'b0;
            md_q    <= 12'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            fill_q  <= fill_d;
            mv_q    <= mv_d;
            md_q    <= md_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
